// File: rtl/srl_sra_iterative_pkg.sv
// Shared constants and FSM state encoding for the iterative right shifter.
package srl_sra_iterative_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned STAGE_W = 5;
  localparam int unsigned AMT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/srl_sra_iterative_srl_stage.sv
// One log-shifter stage: optionally shifts right by 2^stage, filling vacated MSBs with fill.
module srl_sra_iterative_srl_stage #(
  parameter int unsigned N     = 32,
  parameter int unsigned LOG2N = 5
) (
  input  logic [N-1:0]     data,
  input  logic [LOG2N-1:0] stage,
  input  logic             en,
  input  logic             fill,
  output logic [N-1:0]     result
);

  logic [2*N-1:0] ext;
  logic [2*N-1:0] shifted;

  always_comb begin
    ext     = {{N{fill}}, data};
    shifted = ext >> ((2*N)'(1) << stage);
    result  = en ? shifted[N-1:0] : data;
  end

endmodule

// File: rtl/srl_sra_iterative.sv
// Multi-cycle SRL/SRA: one shift stage per clock, valid/ready on both sides.
module srl_sra_iterative
  import srl_sra_iterative_pkg::*;
#(
  parameter int unsigned N     = DATA_W,
  parameter int unsigned LOG2N = STAGE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     X,
  input  logic [AMT_W-1:0] S,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     Z
);

  state_e           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] amt_q, amt_d;
  logic [N-1:0]     data_q, data_d;
  logic             fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic [N-1:0]     z_q, z_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             stage_en;
  logic [N-1:0]     stage_out;

  assign stage_en = |(amt_q & (LOG2N'(1) << cnt_q));

  srl_sra_iterative_srl_stage #(
    .N     (N),
    .LOG2N (LOG2N)
  ) u_stage (
    .data   (data_q),
    .stage  (cnt_q),
    .en     (stage_en),
    .fill   (fill_q),
    .result (stage_out)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      amt_q       <= '0;
      data_q      <= '0;
      fill_q      <= 1'b0;
      ovf_q       <= 1'b0;
      z_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      amt_q       <= amt_d;
      data_q      <= data_d;
      fill_q      <= fill_d;
      ovf_q       <= ovf_d;
      z_q         <= z_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    amt_d       = amt_q;
    data_d      = data_q;
    fill_d      = fill_q;
    ovf_d       = ovf_q;
    z_d         = z_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d     = X;
          amt_d      = S[LOG2N-1:0];
          fill_d     = arith & X[N-1];
          ovf_d      = |S[AMT_W-1:LOG2N];
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = stage_out;
        cnt_d  = cnt_q + LOG2N'(1);
        if (cnt_q == LOG2N'(LOG2N - 1)) begin
          // Out-of-range amounts collapse to pure fill, latency unchanged
          z_d         = ovf_q ? {N{fill_q}} : stage_out;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_srl_sra_iterative.sv
// Scoreboard bench for srl_sra_iterative: directed shifts, boundaries, backpressure, resets.
module tb_srl_sra_iterative;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] S;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Z;

  typedef struct {
    logic [31:0] z;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          seen     = 1'b0;
  logic [31:0] last_z;

  srl_sra_iterative dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .S         (S),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: compare each presented result against the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (!seen) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got Z=0x%08h with no pending op", Z);
        end else begin
          chk("result", Z, sb[0].z);
          chk("latency", 32'(cyc - sb[0].acc), 32'd5);
        end
        seen   = 1'b1;
        last_z = Z;
      end else begin
        chk("z_stable", Z, last_z);
        chk("in_ready_done", {31'd0, in_ready}, 32'd0);
      end
      if (out_ready === 1'b1) begin
        if (sb.size() != 0) void'(sb.pop_front());
        seen = 1'b0;
      end
    end
  end

  task automatic do_op(input logic [31:0] x, input logic [31:0] s, input logic a,
                       input logic [31:0] expz);
    int n;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=%b expected 1", in_ready);
    end
    in_valid = 1'b1;
    X        = x;
    S        = s;
    arith    = a;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X        = $urandom;
    S        = $urandom;
    arith    = 1'b0;
    sb.push_back('{z: expz, acc: cyc});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected 0", sb.size());
    end
  endtask

  initial begin
    int n;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X         = '0;
    S         = '0;
    arith     = 1'b0;

    // Asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_z", Z, 32'd0);
    #13 rst_n = 1'b1;

    do_op(32'h8000_0000, 32'd4,         1'b0, 32'h0800_0000);
    do_op(32'h8000_0000, 32'd4,         1'b1, 32'hF800_0000);
    do_op(32'h7FFF_FFF0, 32'd4,         1'b1, 32'h07FF_FFFF);
    do_op(32'hDEAD_BEEF, 32'd0,         1'b0, 32'hDEAD_BEEF);
    do_op(32'h8000_0000, 32'd31,        1'b0, 32'h0000_0001);
    do_op(32'h8000_0000, 32'd32,        1'b1, 32'hFFFF_FFFF);
    do_op(32'hFFFF_FFFF, 32'h0001_0003, 1'b0, 32'h0000_0000);
    do_op(32'h8000_0000, 32'd31,        1'b1, 32'hFFFF_FFFF);
    do_op(32'h1234_5678, 32'd8,         1'b1, 32'h0012_3456);
    do_op(32'h8765_4321, 32'd12,        1'b1, 32'hFFF8_7654);
    do_op(32'h8765_4321, 32'd33,        1'b0, 32'h0000_0000);
    do_op(32'hDEAD_BEEF, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF);
    do_op(32'h8000_0000, 32'd1,         1'b1, 32'hC000_0000);
    drain();

    // Backpressure: hold DONE while offering a new op that must be ignored
    @(posedge clk);
    #1 out_ready = 1'b0;
    do_op(32'hA5A5_A5A5, 32'd16, 1'b0, 32'h0000_A5A5);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_reached_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      X        = 32'hFFFF_FFFF;
      S        = 32'd1;
      arith    = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_retire_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_retire_ready", {31'd0, in_ready}, 32'd1);
    drain();

    // Reset during SHIFT discards the op
    do_op(32'h1234_5678, 32'd8, 1'b0, 32'h0012_3456);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_z", Z, 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) chk("midrst_no_output", {31'd0, out_valid}, 32'd0);
    end
    chk("midrst_idle", {31'd0, in_ready}, 32'd1);

    do_op(32'h0000_00F0, 32'd4, 1'b0, 32'h0000_000F);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/srl_sra_iterative.md
Name: srl_sra_iterative

Overview:
- Multi-cycle 32-bit right shifter; the counterpart of the combinational left-shift mux slices.
- Supports logical (SRL) and arithmetic (SRA) right shifts.
- Applies one log-shifter stage per clock and uses a valid/ready handshake on input and output.
- Sits beside the ALU; multi-cycle ops (SRL/SRA) are routed to it by the ALU control.

Parameters:
- N, 32, data width in bits.
- LOG2N, 5, number of shift stages; must equal log2(N).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present on X, S, arith.
- in_ready  out  1  block can accept an operation.
- X  in  N  value to shift.
- S  in  32  shift amount; full 32-bit word, as for the left-shift path.
- arith  in  1  1 = SRA (fill with X[N-1]), 0 = SRL (fill with 0).
- out_valid  out  1  Z holds a completed result.
- out_ready  in  1  consumer takes Z.
- Z  out  N  shifted result.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, Z=0, stage counter=0, internal regs=0.
- States: IDLE, SHIFT, DONE (encoding in shared include).
- IDLE:
  - in_ready=1.
  - On edge with in_valid=1: latch data_reg=X, amt_reg=S[LOG2N-1:0], fill_reg=arith&X[N-1], ovf_reg=|S[31:LOG2N]; cnt=0; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - Each edge: if amt_reg[cnt]=1, data_reg shifts right by 2^cnt, vacated MSBs filled with fill_reg; else unchanged.
  - cnt increments. On the edge where cnt==LOG2N-1, go to DONE and load Z.
- Z load value: {N{fill_reg}} if ovf_reg=1, else the final shifted value.
- DONE:
  - out_valid=1, Z stable, in_ready=0.
  - Edge with out_ready=1: go to IDLE, out_valid=0. Z keeps its last value until the next load.
  - out_ready=0: hold indefinitely, no change to Z.
- Latency:
  - out_valid rises exactly LOG2N (5) cycles after the accept edge, independent of the shift amount.
  - Throughput is one op per LOG2N+2 cycles minimum. No accept in the same cycle as output retire (in_ready is low in DONE).
- Shift amount rules:
  - Shift amount 0: Z=X.
  - S >= N (any bit of S[31:5] set): Z = all zeros (SRL) or all copies of X[31] (SRA). Latency is unchanged.
- Inputs while busy: in_valid outside IDLE is ignored; X/S/arith may change freely.
- out_ready while not in DONE: ignored.
- Reset mid-operation: immediate return to reset values; the in-flight op is discarded and no out_valid is produced.
- Stage counter width: LOG2N bits; it never wraps within an op.

Decomposition:
- Shared include (e.g. shift_defs.vh): state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the N/LOG2N defaults.
- Sub-module srl_stage:
  - Combinational single stage.
  - Inputs: data[N-1:0], stage index (cnt), enable (amt_reg[cnt]), fill.
  - Output: data shifted right by 2^cnt with fill when enabled.
  - Instantiated once and reused each cycle.
- Top level holds the FSM, counter and registers.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> in_ready=1, out_valid=0, Z=0 immediately.
- SRL basic: X=0x80000000, S=4, arith=0 -> out_valid 5 cycles after accept, Z=0x08000000.
- SRA sign fill: X=0x80000000, S=4, arith=1 -> Z=0xF8000000. Then X=0x7FFFFFF0, S=4, arith=1 -> Z=0x07FFFFFF.
- Boundaries:
  - S=0, X=0xDEADBEEF -> Z=0xDEADBEEF.
  - S=31, X=0x80000000, SRL -> Z=0x00000001.
  - S=32, X=0x80000000, SRA -> Z=0xFFFFFFFF.
  - S=0x00010003, SRL -> Z=0.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, Z stable, in_ready=0, new in_valid ignored. Raise out_ready -> IDLE next cycle.
- Reset mid-op: accept X=0x12345678, S=8, pulse rst_n low at cycle 2 of SHIFT -> out_valid never asserts. A subsequent op X=0xF0, S=4, SRL -> Z=0x0000000F.
